audio_dac_tx: RTL and testbench

AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

---
 rtl/audio_dac_tx_pkg.sv | 14 +
 rtl/audio_dac_tx_if.sv | 24 ++
 rtl/audio_dac_tx_sample_fifo.sv | 53 +++++
 rtl/audio_dac_tx.sv | 161 ++++++++++++++++
 tb/tb_audio_dac_tx.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/audio_dac_tx_pkg.sv
// Shared definitions for the audio DAC transmit path: parameter defaults and FSM states.
package audio_dac_tx_pkg;

    localparam int unsigned N_DEFAULT          = 16;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        LOAD       = 2'd1,
        SHIFT      = 2'd2,
        PAD        = 2'd3
    } tx_state_e;

endpackage

// File: rtl/audio_dac_tx_if.sv
// Sample stream handshake between a PCM source and the DAC transmitter.
interface audio_dac_tx_if
    import audio_dac_tx_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) ();

    logic [N-1:0] sample_data;
    logic         sample_valid;
    logic         sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/audio_dac_tx_sample_fifo.sv
// Sample buffer between the PCM stream and the frame register; flags come from registered pointers.
module sample_fifo
    import audio_dac_tx_pkg::*;
#(
    parameter int unsigned N          = N_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [N-1:0] mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S DAC transmitter: buffers PCM samples and serialises one mono word per frame half
// against codec-driven bclk/daclrck, which are resynchronised into the clk domain.
module audio_dac_tx
    import audio_dac_tx_pkg::*;
#(
    parameter int unsigned N          = N_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    audio_dac_tx_if.slave dstream,
    input  logic          bclk,
    input  logic          daclrck,
    output logic          dacdat,
    output logic          underflow
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [1:0]       bclk_sync;
    logic [1:0]       lrck_sync;
    logic             bclk_q;
    logic             lrck_q;
    logic             bclk_fall;
    logic             lrck_fall;
    logic             lrck_rise;
    logic             lrck_edge;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [N-1:0]     fifo_rdata;
    logic [N-1:0]     frame_word;

    tx_state_e        state;
    tx_state_e        state_next;
    logic             load_en;
    logic             shift_en;
    logic             pad_en;
    logic [N-1:0]     shifter;
    logic [CNT_W-1:0] bit_cnt;

    // Two-flop synchronisers followed by an edge-detect stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], bclk};
            lrck_sync <= {lrck_sync[0], daclrck};
            bclk_q    <= bclk_sync[1];
            lrck_q    <= lrck_sync[1];
        end
    end

    assign bclk_fall = bclk_q & ~bclk_sync[1];
    assign lrck_fall = lrck_q & ~lrck_sync[1];
    assign lrck_rise = ~lrck_q & lrck_sync[1];
    assign lrck_edge = lrck_fall | lrck_rise;

    assign dstream.sample_ready = ~fifo_full;
    assign fifo_push            = dstream.sample_valid & ~fifo_full;
    assign fifo_pop             = lrck_fall & ~fifo_empty;

    sample_fifo #(
        .N          (N),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (dstream.sample_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Left frame start latches the next sample (silence if none) for both halves.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_word <= '0;
            underflow  <= 1'b0;
        end else begin
            underflow <= lrck_fall & fifo_empty;
            if (lrck_fall) begin
                frame_word <= fifo_empty ? '0 : fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_next;
        end
    end

    // Frame edges take priority over a coincident bclk edge.
    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        pad_en     = 1'b0;
        case (state)
            WAIT_FRAME: begin
                if (lrck_fall) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (lrck_edge) begin
                    state_next = LOAD;
                end else if (bclk_fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(1)) begin
                        state_next = PAD;
                    end
                end
            end
            PAD: begin
                if (lrck_edge) begin
                    state_next = LOAD;
                end else if (bclk_fall) begin
                    pad_en = 1'b1;
                end
            end
            default: begin
                state_next = WAIT_FRAME;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shifter <= '0;
            bit_cnt <= '0;
            dacdat  <= 1'b0;
        end else begin
            if (load_en) begin
                shifter <= frame_word;
                bit_cnt <= CNT_W'(N);
            end else if (shift_en) begin
                dacdat  <= shifter[N-1];
                shifter <= {shifter[N-2:0], 1'b0};
                bit_cnt <= bit_cnt - CNT_W'(1);
            end else if (pad_en) begin
                dacdat  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Self-checking bench for audio_dac_tx: table of I2S frames plus stream, reset and start-up sequences.
module tb_audio_dac_tx;

    localparam int unsigned W         = 16;
    localparam int unsigned BCLK_HALF = 6;

    logic clk = 1'b0;
    logic reset;
    logic bclk;
    logic daclrck;
    logic dacdat;
    logic underflow;

    audio_dac_tx_if #(.N(W)) dstream ();

    audio_dac_tx #(.N(W), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .dstream   (dstream),
        .bclk      (bclk),
        .daclrck   (daclrck),
        .dacdat    (dacdat),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sample;
        bit           push;
        int           nb;
        int           exp_uf;
    } vec_t;

    vec_t         vecs [9];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] sb_q [$];
    logic [W-1:0] cur_word;
    bit           active;
    logic         prev_bit;
    int           uf_exp;
    int           uf_seen;
    int           accepted;
    bit           stream_en;
    logic [W-1:0] stream_val;
    bit           push_req;
    logic [W-1:0] push_data;

    assign dstream.sample_valid = stream_en | push_req;
    assign dstream.sample_data  = stream_en ? stream_val : push_data;

    // Accepted samples become expected words; underflow pulses are counted.
    always @(posedge clk) begin
        if (!reset && dstream.sample_valid && dstream.sample_ready) begin
            sb_q.push_back(dstream.sample_data);
            accepted++;
            if (stream_en) stream_val <= stream_val + W'(1);
        end
        if (underflow === 1'b1) uf_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_sample(input logic [W-1:0] s);
        int start;
        start = accepted;
        @(negedge clk);
        push_data = s;
        push_req  = 1'b1;
        for (int i = 0; i < 50 && accepted == start; i++) @(negedge clk);
        push_req = 1'b0;
        check("push accepted", 32'(accepted - start), 32'd1);
    endtask

    // bclk periods k_from..k_to-1 of one frame half; k==0 carries the daclrck edge.
    task automatic drive_bits(input logic lvl, input int k_from, input int k_to);
        logic exp_bit;
        for (int k = k_from; k < k_to; k++) begin
            @(negedge clk);
            bclk = 1'b0;
            if (k == 0) begin
                daclrck = lvl;
                if (!lvl) begin
                    active = 1'b1;
                    if (sb_q.size() > 0) cur_word = sb_q.pop_front();
                    else begin
                        cur_word = '0;
                        uf_exp++;
                    end
                end
            end
            if (k == 0)                       exp_bit = prev_bit;
            else if (!active || k > int'(W))  exp_bit = 1'b0;
            else                              exp_bit = cur_word[W - k];
            repeat (BCLK_HALF - 1) @(negedge clk);
            check($sformatf("dacdat lr%0d k%0d", lvl, k), 32'(dacdat), 32'(exp_bit));
            prev_bit = exp_bit;
            @(negedge clk);
            bclk = 1'b1;
            repeat (BCLK_HALF - 1) @(negedge clk);
        end
    endtask

    task automatic drive_frame(input int nb);
        drive_bits(1'b0, 0, nb);
        drive_bits(1'b1, 0, nb);
    endtask

    initial begin
        int uf0;
        int base;

        reset      = 1'b1;
        bclk       = 1'b1;
        daclrck    = 1'b1;
        stream_en  = 1'b0;
        stream_val = '0;
        push_req   = 1'b0;
        push_data  = '0;
        active     = 1'b0;
        prev_bit   = 1'b0;
        cur_word   = '0;
        uf_exp     = 0;
        uf_seen    = 0;
        accepted   = 0;

        vecs[0] = '{16'h0000, 1'b0, 18, 0};
        vecs[1] = '{16'h8001, 1'b1, 17, 0};
        vecs[2] = '{16'h0000, 1'b0, 18, 1};
        vecs[3] = '{16'h0000, 1'b0, 18, 1};
        vecs[4] = '{16'h0000, 1'b0, 18, 1};
        vecs[5] = '{16'h7FFF, 1'b1, 20, 0};
        vecs[6] = '{16'hFFFF, 1'b1, 16, 0};
        vecs[7] = '{16'h1234, 1'b1, 10, 0};
        vecs[8] = '{16'h5A5A, 1'b1, 18, 0};

        repeat (4) @(negedge clk);
        check("reset dacdat", 32'(dacdat), 32'd0);
        check("reset underflow", 32'(underflow), 32'd0);
        check("reset ready", 32'(dstream.sample_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", 32'(dstream.sample_ready), 32'd1);

        // Start inside a right half: nothing may be sent before the first left edge.
        push_sample(16'hA5C3);
        drive_bits(1'b1, 0, 18);
        check("no underflow before left edge", 32'(uf_seen), 32'd0);

        for (int v = 0; v < 9; v++) begin
            uf0 = uf_seen;
            if (vecs[v].push) push_sample(vecs[v].sample);
            drive_frame(vecs[v].nb);
            check($sformatf("vec%0d underflow count", v), 32'(uf_seen - uf0), 32'(vecs[v].exp_uf));
        end

        // Continuous valid: fill, then exactly one refill per left frame, in order.
        base       = accepted;
        stream_val = 16'hFFF0;
        @(negedge clk);
        stream_en = 1'b1;
        repeat (30) @(negedge clk);
        check("stream fill count", 32'(accepted - base), 32'd4);
        check("stream ready low", 32'(dstream.sample_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_frame(18);
            check($sformatf("stream refill %0d", i), 32'(accepted - base), 32'(5 + i));
        end
        @(negedge clk);
        stream_en = 1'b0;

        // Reset while the 7th data bit is on the line: word and buffered samples are dropped.
        drive_bits(1'b0, 0, 8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid-word reset dacdat", 32'(dacdat), 32'd0);
        check("mid-word reset ready", 32'(dstream.sample_ready), 32'd1);
        check("mid-word reset underflow", 32'(underflow), 32'd0);
        reset    = 1'b0;
        active   = 1'b0;
        prev_bit = 1'b0;
        cur_word = '0;
        sb_q.delete();
        drive_bits(1'b0, 8, 18);
        drive_bits(1'b1, 0, 18);
        uf0 = uf_seen;
        drive_frame(18);
        check("post-reset underflow", 32'(uf_seen - uf0), 32'd1);
        uf0 = uf_seen;
        push_sample(16'h6E21);
        drive_frame(18);
        check("post-reset resume underflow", 32'(uf_seen - uf0), 32'd0);
        check("total underflow", 32'(uf_seen), 32'(uf_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20_000_000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
